// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: issues loads/stores on the
// req/gnt/rvalid data bus and produces a registered writeback bundle.
module mem_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              reg_w,
    input  logic [4:0]        rd,
    input  logic [31:0]       reg_data,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic [1:0]        mem_len,
    input  logic              mem_uns,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_w,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_exc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]         dmem_wdata_q, dmem_wdata_d;
    logic [3:0]          dmem_wstrb_q, dmem_wstrb_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_reg_w_q, wb_reg_w_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic                wb_exc_q, wb_exc_d;
    logic                cap_reg_w_q, cap_reg_w_d;
    logic [4:0]          cap_rd_q, cap_rd_d;
    logic [1:0]          cap_len_q, cap_len_d;
    logic                cap_uns_q, cap_uns_d;
    logic [1:0]          cap_off_q, cap_off_d;

    logic                is_mem;
    logic                mis;
    logic [1:0]          off;
    logic [3:0]          st_wstrb;
    logic [31:0]         st_wdata;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         ld_val;

    assign off    = mem_addr[1:0];
    assign is_mem = mem_r | mem_w;
    assign mis    = (mem_len == 2'd1 && off[0]) ||
                    (mem_len == 2'd2 && off != 2'd0) ||
                    (mem_len == 2'd3);

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = mem_data;
        case (mem_len)
            2'd0: begin
                st_wstrb = 4'b0001 << off;
                st_wdata = {4{mem_data[7:0]}};
            end
            2'd1: begin
                st_wstrb = 4'b0011 << off;
                st_wdata = {2{mem_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset captured at issue, not the live inputs.
    assign ld_byte = dmem_rdata[{cap_off_q, 3'b000} +: 8];
    assign ld_half = dmem_rdata[{cap_off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (cap_len_q)
            2'd0:    ld_val = {{24{~cap_uns_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_val = {{16{~cap_uns_q & ld_half[15]}}, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_wstrb_d = dmem_wstrb_q;
        wb_valid_d   = 1'b0;
        wb_reg_w_d   = wb_reg_w_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_exc_d     = wb_exc_q;
        cap_reg_w_d  = cap_reg_w_q;
        cap_rd_d     = cap_rd_q;
        cap_len_d    = cap_len_q;
        cap_uns_d    = cap_uns_q;
        cap_off_d    = cap_off_q;
        stall        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_reg_w_d = reg_w;
                        wb_rd_d    = rd;
                        wb_data_d  = reg_data;
                        wb_exc_d   = 1'b0;
                    end else if (mis) begin
                        wb_valid_d = 1'b1;
                        wb_reg_w_d = 1'b0;
                        wb_rd_d    = rd;
                        wb_data_d  = 32'(mem_addr);
                        wb_exc_d   = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        state_d      = S_REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mem_w;
                        dmem_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                        dmem_wstrb_d = mem_w ? st_wstrb : '0;
                        dmem_wdata_d = mem_w ? st_wdata : '0;
                        cap_reg_w_d  = reg_w;
                        cap_rd_d     = rd;
                        cap_len_d    = mem_len;
                        cap_uns_d    = mem_uns;
                        cap_off_d    = off;
                    end
                end
            end

            S_REQ: begin
                stall = 1'b1;
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    if (dmem_we_q) begin
                        // Store completes on grant: release upstream immediately.
                        stall      = 1'b0;
                        wb_valid_d = 1'b1;
                        wb_reg_w_d = 1'b0;
                        wb_rd_d    = cap_rd_q;
                        wb_exc_d   = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                stall = ~dmem_rvalid;
                if (dmem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_reg_w_d = cap_reg_w_q;
                    wb_rd_d    = cap_rd_q;
                    wb_data_d  = ld_val;
                    wb_exc_d   = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wstrb_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_reg_w_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_exc_q     <= 1'b0;
            cap_reg_w_q  <= 1'b0;
            cap_rd_q     <= '0;
            cap_len_q    <= '0;
            cap_uns_q    <= 1'b0;
            cap_off_q    <= '0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_wstrb_q <= dmem_wstrb_d;
            wb_valid_q   <= wb_valid_d;
            wb_reg_w_q   <= wb_reg_w_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            wb_exc_q     <= wb_exc_d;
            cap_reg_w_q  <= cap_reg_w_d;
            cap_rd_q     <= cap_rd_d;
            cap_len_q    <= cap_len_d;
            cap_uns_q    <= cap_uns_d;
            cap_off_q    <= cap_off_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wstrb = dmem_wstrb_q;
    assign wb_valid   = wb_valid_q;
    assign wb_reg_w   = wb_reg_w_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign wb_exc     = wb_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset/back-to-back sequences,
// and random transactions checked against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, reg_w, mem_r, mem_w, mem_uns;
    logic [4:0]  rd;
    logic [31:0] reg_data, mem_addr, mem_data;
    logic [1:0]  mem_len;
    logic        stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_reg_w, wb_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int vectors = 0;
    int miscompares = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .reg_w(reg_w), .rd(rd),
        .reg_data(reg_data), .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_len(mem_len), .mem_uns(mem_uns), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_reg_w(wb_reg_w), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reg_w;
        logic [4:0]  rd;
        logic [31:0] reg_data;
        logic        mem_r, mem_w;
        logic [31:0] addr, data;
        logic [1:0]  len;
        logic        uns;
        int          gw, rw;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic        bus, we;
        logic [31:0] baddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        reg_w;
        logic [31:0] data;
        logic        exc;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic op_t mk(logic rw_, logic [4:0] rd_, logic [31:0] rdat, logic r, logic w,
                               logic [31:0] a, logic [31:0] d, logic [1:0] l, logic u,
                               int g, int v, logic [31:0] rdt);
        op_t o;
        o.reg_w = rw_; o.rd = rd_; o.reg_data = rdat; o.mem_r = r; o.mem_w = w;
        o.addr = a; o.data = d; o.len = l; o.uns = u; o.gw = g; o.rw = v; o.rdata = rdt;
        return o;
    endfunction

    function automatic exp_t mke(logic b, logic w, logic [31:0] ba, logic [3:0] s,
                                 logic [31:0] wd, logic rw_, logic [31:0] d, logic x);
        exp_t e;
        e.bus = b; e.we = w; e.baddr = ba; e.wstrb = s; e.wdata = wd;
        e.reg_w = rw_; e.data = d; e.exc = x;
        return e;
    endfunction

    // Transaction-level reference: access size in bytes, alignment by modulo.
    function automatic exp_t model(op_t o);
        exp_t e;
        int unsigned size, off;
        longint unsigned v, m;
        e = '{default: '0};
        size = (o.len == 2'd0) ? 1 : (o.len == 2'd1) ? 2 : (o.len == 2'd2) ? 4 : 0;
        if (!o.mem_r && !o.mem_w) begin
            e.reg_w = o.reg_w;
            e.data  = o.reg_data;
        end else if (size == 0 || (o.addr % size) != 0) begin
            e.exc  = 1'b1;
            e.data = o.addr;
        end else begin
            off     = o.addr % 4;
            e.bus   = 1'b1;
            e.we    = o.mem_w;
            e.baddr = o.addr - off;
            if (o.mem_w) begin
                for (int b = 0; b < 4; b++) begin
                    e.wstrb[b] = (b >= int'(off)) && (b < int'(off + size));
                    e.wdata[8*b +: 8] = o.data[8*(b % int'(size)) +: 8];
                end
            end else begin
                m = 64'd1 << (8 * size);
                v = ({32'd0, o.rdata} >> (8 * off)) % m;
                if (!o.uns && size < 4 && v >= m / 2) v = v + (64'd1 << 32) - m;
                e.data  = v[31:0];
                e.reg_w = o.reg_w;
            end
        end
        return e;
    endfunction

    // Called at #1 after a clock edge with the DUT in IDLE; returns #1 after completion edge.
    task automatic run_op(input op_t o, input exp_t e);
        in_valid = 1'b1; reg_w = o.reg_w; rd = o.rd; reg_data = o.reg_data;
        mem_r = o.mem_r; mem_w = o.mem_w; mem_addr = o.addr; mem_data = o.data;
        mem_len = o.len; mem_uns = o.uns; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("stall_accept", stall, e.bus);
        @(posedge clk); #1;
        if (e.bus) begin
            for (int k = 0; k <= o.gw; k++) begin
                chk("req", dmem_req, 1);
                chk("req_we", dmem_we, e.we);
                chk("req_addr", dmem_addr, e.baddr);
                chk("req_wstrb", dmem_wstrb, e.wstrb);
                if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
                chk("wb_valid_req", wb_valid, 0);
                dmem_gnt = (k == o.gw);
                @(negedge clk);
                chk("stall_req", stall, !(e.we && k == o.gw));
                @(posedge clk); #1;
            end
            dmem_gnt = 1'b0;
            chk("req_drop", dmem_req, 0);
            if (!e.we) begin
                for (int j = 0; j <= o.rw; j++) begin
                    chk("wb_valid_resp", wb_valid, 0);
                    dmem_rvalid = (j == o.rw);
                    dmem_rdata  = (j == o.rw) ? o.rdata : $urandom;
                    @(negedge clk);
                    chk("stall_resp", stall, j != o.rw);
                    @(posedge clk); #1;
                end
                dmem_rvalid = 1'b0;
            end
        end else begin
            chk("no_req", dmem_req, 0);
        end
        chk("wb_valid", wb_valid, 1);
        chk("wb_reg_w", wb_reg_w, e.reg_w);
        chk("wb_exc", wb_exc, e.exc);
        if (!(e.bus && e.we)) chk("wb_data", wb_data, e.data);
        if (!e.exc && !(e.bus && e.we)) chk("wb_rd", wb_rd, o.rd);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_idle", stall, 0);
        @(posedge clk); #1;
        chk("wb_valid_idle", wb_valid, 0);
        chk("req_idle", dmem_req, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dmem_req"}, dmem_req, 0);
        chk({tag, "_dmem_we"}, dmem_we, 0);
        chk({tag, "_dmem_addr"}, dmem_addr, 0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
        chk({tag, "_dmem_wstrb"}, dmem_wstrb, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_reg_w"}, wb_reg_w, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_wb_exc"}, wb_exc, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        op_t  o;
        int   kind;
        logic [31:0] a;

        tbl[0]  = '{mk(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    mke(0, 0, 0, 0, 0, 1, 32'h1234, 0)};
        tbl[1]  = '{mk(0, 3, 0, 0, 1, 32'h1003, 32'hAB, 0, 0, 2, 0, 0),
                    mke(1, 1, 32'h1000, 4'b1000, 32'hABABABAB, 0, 0, 0)};
        tbl[2]  = '{mk(1, 7, 0, 1, 0, 32'h2002, 0, 1, 0, 1, 2, 32'h8001_7FFF),
                    mke(1, 0, 32'h2000, 4'b0000, 0, 1, 32'hFFFF8001, 0)};
        tbl[3]  = '{mk(1, 7, 0, 1, 0, 32'h2002, 0, 1, 1, 0, 1, 32'h8001_7FFF),
                    mke(1, 0, 32'h2000, 4'b0000, 0, 1, 32'h00008001, 0)};
        tbl[4]  = '{mk(1, 8, 0, 1, 0, 32'h2001, 0, 0, 1, 1, 0, 32'h8001_7FFF),
                    mke(1, 0, 32'h2000, 4'b0000, 0, 1, 32'h0000007F, 0)};
        tbl[5]  = '{mk(1, 9, 0, 1, 0, 32'h3002, 0, 2, 0, 0, 0, 0),
                    mke(0, 0, 0, 0, 0, 0, 32'h3002, 1)};
        tbl[6]  = '{mk(1, 9, 0, 1, 0, 32'h2000, 0, 0, 0, 0, 0, 32'h8001_7FFF),
                    mke(1, 0, 32'h2000, 4'b0000, 0, 1, 32'hFFFFFFFF, 0)};
        tbl[7]  = '{mk(0, 1, 0, 0, 1, 32'h1002, 32'h1234CAFE, 1, 0, 1, 0, 0),
                    mke(1, 1, 32'h1000, 4'b1100, 32'hCAFECAFE, 0, 0, 0)};
        tbl[8]  = '{mk(0, 1, 0, 0, 1, 32'h1004, 32'hDEADBEEF, 2, 0, 0, 0, 0),
                    mke(1, 1, 32'h1004, 4'b1111, 32'hDEADBEEF, 0, 0, 0)};
        tbl[9]  = '{mk(1, 2, 0, 1, 0, 32'h40, 0, 3, 0, 0, 0, 0),
                    mke(0, 0, 0, 0, 0, 0, 32'h40, 1)};
        tbl[10] = '{mk(0, 2, 0, 0, 1, 32'h1001, 32'h55, 1, 0, 0, 0, 0),
                    mke(0, 0, 0, 0, 0, 0, 32'h1001, 1)};
        tbl[11] = '{mk(1, 4, 0, 1, 1, 32'h10, 32'h5555AAAA, 2, 0, 3, 0, 0),
                    mke(1, 1, 32'h10, 4'b1111, 32'h5555AAAA, 0, 0, 0)};
        tbl[12] = '{mk(1, 31, 0, 1, 0, 32'h3000, 0, 2, 1, 0, 0, 32'h87654321),
                    mke(1, 0, 32'h3000, 4'b0000, 0, 1, 32'h87654321, 0)};
        tbl[13] = '{mk(0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    mke(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0)};
        tbl[14] = '{mk(1, 6, 0, 1, 0, 32'h2003, 0, 0, 0, 2, 1, 32'h8001_7FFF),
                    mke(1, 0, 32'h2000, 4'b0000, 0, 1, 32'hFFFFFF80, 0)};

        reset = 1'b0; in_valid = 0; reg_w = 0; rd = 0; reg_data = 0; mem_r = 0;
        mem_w = 0; mem_addr = 0; mem_data = 0; mem_len = 0; mem_uns = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b1;
        idle_cycle();

        // Entries run back-to-back; 12 -> 13 is the zero-wait LW followed by an ALU op.
        for (int i = 0; i < 15; i++) run_op(tbl[i].op, tbl[i].e);
        idle_cycle();

        // Reset while waiting for read data; the late rvalid must be dropped.
        run_op(tbl[0].op, tbl[0].e);
        in_valid = 1'b1; mem_r = 1; mem_w = 0; mem_addr = 32'h3000; mem_len = 2;
        @(posedge clk); #1;
        chk("rst_seq_req", dmem_req, 1);
        dmem_gnt = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("rst_seq_resp_stall", stall, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
        chk_zero("midreset");
        @(negedge clk);
        chk("midreset_stall", stall, 0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("late_rvalid_wb", wb_valid, 0);
        chk("late_rvalid_req", dmem_req, 0);
        run_op(tbl[0].op, tbl[0].e);

        for (int n = 0; n < 300; n++) begin
            o.reg_w = 1'($urandom_range(0, 1));
            o.rd = 5'($urandom_range(0, 31));
            o.reg_data = $urandom; o.data = $urandom; o.rdata = $urandom;
            o.len = 2'($urandom_range(0, 3));
            o.uns = 1'($urandom_range(0, 1));
            o.gw = $urandom_range(0, 3);
            o.rw = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            o.mem_r = (kind >= 3 && kind < 6) || kind == 9;
            o.mem_w = kind >= 6;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (o.len == 2'd1) a[0] = 1'b0;
                if (o.len == 2'd2) a[1:0] = 2'b00;
            end
            o.addr = a;
            run_op(o, model(o));
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
